// File: rtl/rip_mem_access_unit.sv
// rip_mem_access_unit: byte/half/word load-store unit over a 32-bit word memory, splitting unaligned accesses into two word operations
package rip_const;
    localparam int B_WIDTH = 8;
endpackage

module rip_mem_access_unit
    import rip_const::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [2:0]              req_funct3,
    input  logic [ADDR_WIDTH+1:0]   req_addr,
    input  logic [31:0]             req_wdata,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [31:0]             resp_rdata,
    output logic                    resp_err,
    output logic                    mem_en,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [32/B_WIDTH-1:0]   mem_we,
    output logic [31:0]             mem_din,
    input  logic [31:0]             mem_dout
);
    localparam int NB = 32 / B_WIDTH;

    typedef enum logic [2:0] {IDLE, ISSUE1, ISSUE2, WAIT, RESP} state_t;

    state_t                  state;
    logic                    we_q;
    logic                    split_q;
    logic [2:0]              f3_q;
    logic [1:0]              off_q;
    logic [ADDR_WIDTH-1:0]   word_q;
    logic [31:0]             wdata_q;
    logic [31:0]             buf_lo;
    logic                    req_err;
    logic                    req_split;
    logic [NB-1:0]           size_mask;
    logic [2*NB-1:0]         lane_wide;
    logic [63:0]             wr_wide;
    logic [31:0]             raw;
    logic [31:0]             load_data;

    assign req_err   = (req_funct3[1:0] == 2'b11) || (req_funct3[2] && (req_we || req_funct3[1]));
    assign req_split = req_funct3[1] ? (req_addr[1:0] != 2'b00) : (req_funct3[0] && req_addr[1:0] == 2'b11);

    assign size_mask = f3_q[1] ? 4'b1111 : f3_q[0] ? 4'b0011 : 4'b0001;
    assign lane_wide = {{NB{1'b0}}, size_mask} << off_q;
    assign wr_wide   = {32'b0, wdata_q} << (off_q * B_WIDTH);

    assign mem_en   = (state == ISSUE1) || (state == ISSUE2);
    assign mem_addr = (state == ISSUE1) ? word_q : (state == ISSUE2) ? word_q + ADDR_WIDTH'(1) : '0;
    assign mem_we   = !we_q ? '0 : (state == ISSUE1) ? lane_wide[NB-1:0] : (state == ISSUE2) ? lane_wide[2*NB-1:NB] : '0;
    assign mem_din  = !we_q ? '0 : (state == ISSUE1) ? wr_wide[31:0] : (state == ISSUE2) ? wr_wide[63:32] : '0;

    // The last read word arrives in WAIT; an earlier first word of a split access sits in buf_lo.
    assign raw       = 32'({mem_dout, split_q ? buf_lo : mem_dout} >> (off_q * B_WIDTH));
    assign load_data = f3_q[1] ? raw :
                       f3_q[0] ? {{16{~f3_q[2] & raw[15]}}, raw[15:0]} :
                                 {{24{~f3_q[2] & raw[7]}}, raw[7:0]};

    // Request/response FSM with registered handshake and response outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            req_ready  <= 1'b0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else begin
            if (state == ISSUE2 && !we_q)
                buf_lo <= mem_dout;
            case (state)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        req_ready <= 1'b0;
                        we_q      <= req_we;
                        f3_q      <= req_funct3;
                        off_q     <= req_addr[1:0];
                        word_q    <= req_addr[ADDR_WIDTH+1:2];
                        wdata_q   <= req_wdata;
                        split_q   <= req_split;
                        if (req_err) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                            resp_rdata <= '0;
                            resp_err   <= 1'b1;
                        end else begin
                            state <= ISSUE1;
                        end
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                ISSUE1: begin
                    state <= split_q ? ISSUE2 : !we_q ? WAIT : RESP;
                    if (!split_q && we_q) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                ISSUE2: begin
                    state <= we_q ? RESP : WAIT;
                    if (we_q) begin
                        resp_valid <= 1'b1;
                        resp_rdata <= '0;
                        resp_err   <= 1'b0;
                    end
                end
                WAIT: begin
                    state      <= RESP;
                    resp_valid <= 1'b1;
                    resp_rdata <= load_data;
                    resp_err   <= 1'b0;
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        req_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/rip_mem_access_unit.md
RIP_MEM_ACCESS_UNIT -- requirements
Module: rip_mem_access_unit

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, meaning memory word-address width (depth 2**ADDR_WIDTH words of 32 bits).
REQ-002 SHALL fix data width at 32 bits with byte width B_WIDTH (8) from rip_const, giving a 4-bit byte-write mask.
REQ-003 SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rstn  input  1  synchronous active-low reset.
REQ-006 req_valid  input  1  request present.
REQ-007 req_ready  output  1  unit accepts a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_funct3  input  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU, 101 HU.
REQ-010 req_addr  input  ADDR_WIDTH+2  byte address.
REQ-011 req_wdata  input  32  store data, right-aligned.
REQ-012 resp_valid  output  1  response present.
REQ-013 resp_ready  input  1  consumer takes the response.
REQ-014 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 resp_err  output  1  illegal funct3 for the given direction.
REQ-016 mem_en  output  1  memory port enable.
REQ-017 mem_addr  output  ADDR_WIDTH  memory word address.
REQ-018 mem_we  output  4  per-byte write enables; bit i covers bits 8i+7:8i.
REQ-019 mem_din  output  32  memory write data.
REQ-020 mem_dout  input  32  memory read data, valid the cycle after mem_en with mem_we=0.

Function
REQ-021 SHALL implement states IDLE, ISSUE1, ISSUE2, WAIT, RESP.
REQ-022 SHALL assert req_ready only in IDLE; req_valid&req_ready in cycle T captures all req_* fields.
REQ-023 SHALL use size s = 1/2/4 for funct3 x00/x01/010, byte offset o = req_addr[1:0], word w = req_addr[ADDR_WIDTH+1:2], little-endian lanes.
REQ-024 SHALL classify an access as split when o+s>4; the second word is (w+1) mod 2**ADDR_WIDTH, so the last word wraps to word 0.
REQ-025 SHALL treat illegal funct3 (011, 110, 111; 100/101 with req_we=1) as error: IDLE->RESP, no mem_en, resp_err=1, resp_rdata=0, resp_valid from T+1.
REQ-026 SHALL drive mem_en=1 only in ISSUE1/ISSUE2; mem_we=0 and mem_din=0 at all other times and for loads.
REQ-027 ISSUE1: mem_addr=w, mem_we lanes o..min(o+s,4)-1, mem_din = wdata shifted left 8*o bits (truncated to 32).
REQ-028 ISSUE2: mem_addr=w+1 (wrapped), mem_we lanes 0..o+s-5, mem_din lanes hold the remaining high-order wdata bytes starting at lane 0.
REQ-029 Transitions: ISSUE1 -> ISSUE2 if split, else WAIT for loads, else RESP; ISSUE2 -> WAIT for loads, else RESP; WAIT -> RESP; RESP -> IDLE when resp_ready.
REQ-030 SHALL capture mem_dout in the cycle after each read issue and assemble bytes in address order.
REQ-031 SHALL sign-extend from bit 8s-1 for B/H; zero-extend for BU/HU; W unchanged.
REQ-032 Latency from accept cycle T to first resp_valid: aligned store T+2, split store T+3, aligned load T+3, split load T+4.
REQ-033 SHALL hold resp_valid, resp_rdata, resp_err stable in RESP until resp_ready; resp_ready with resp_valid=0 has no effect.
REQ-034 SHALL not accept a request in the RESP cycle where resp_ready=1; the next accept is one cycle later in IDLE.
REQ-035 SHALL register resp_rdata and resp_err; mem_* may be decoded from state and captured registers, with no combinational path from req_* to mem_*.

Reset
REQ-036 While rstn=0 at a clock edge: state IDLE, req_ready=0 during reset, resp_valid=0, resp_rdata=0, resp_err=0, mem_en=0, mem_we=0, mem_addr=0, mem_din=0.
REQ-037 In the first cycle after rstn rises: req_ready=1.
REQ-038 Reset mid-operation SHALL abort the operation with no further mem_en and no response; the first half of a split store may already be written.

Verification
REQ-039 SW to addr 0x008, wdata 0xDEADBEEF -> T+1 mem_addr=2, mem_we=1111, mem_din=0xDEADBEEF; resp_valid at T+2, rdata 0, err 0.
REQ-040 SB to 0x00D, wdata 0x000000A5 -> mem_addr=3, mem_we=0010, mem_din=0x0000A500; then LBU 0x00D -> rdata 0x000000A5; LB 0x00D -> 0xFFFFFFA5.
REQ-041 SW to 0x006, wdata 0x11223344 -> ISSUE1 word 1, we=1100, din=0x33440000; ISSUE2 word 2, we=0011, din=0x00001122; then LW 0x006 -> 0x11223344 at T+4.
REQ-042 LH at 0xFFF (ADDR_WIDTH=10), word 1023 byte3=0x80, word 0 byte0=0x7F -> second read at mem_addr=0; rdata 0x00007F80.
REQ-043 Load with funct3=011 -> no mem_en, resp_valid at T+1, resp_err=1, rdata 0; with resp_ready held 0 for 3 cycles, outputs stay stable and req_ready stays 0.
REQ-044 rstn low during ISSUE2 of a split load -> next cycle resp_valid=0 and mem_en=0; after release, req_ready=1 and a fresh LW returns correct data.
